keypad_conditioner: RTL and testbench

- Front-end stage that sits directly upstream of the digital lock statemachine and drives its `key` input.
- Takes the four raw, bouncy, active-low board push-buttons and synchronises each one into the clock domain, then debounces each one independently.
- Enforces one-hot key output. A multi-key press is rejected and produces no digit until every key has been released.
- The lock accepts any non-zero `key` as a digit, so this block guarantees that only clean single presses ever reach it.

---
 rtl/keypad_conditioner_if.sv | 24 ++
 rtl/keypad_conditioner.sv | 123 ++++++++++++
 tb/tb_keypad_conditioner.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_conditioner_if.sv
// Keypad front-end bundle: raw active-low buttons in,
// conditioned one-hot key, strobe and lockout flag out.
interface keypad_conditioner_if #(
    parameter int NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] key_n;
    logic [NUM_KEYS-1:0] key;
    logic                keyStrobe;
    logic                multiKey;

    modport master (
        input  key_n,
        output key,
        output keyStrobe,
        output multiKey
    );

    modport slave (
        output key_n,
        input  key,
        input  keyStrobe,
        input  multiKey
    );
endinterface

// File: rtl/keypad_conditioner.sv
// Keypad conditioner: 2-flop sync, per-key debounce and a
// one-hot output FSM that locks out multi-key presses.
module keypad_conditioner #(
    parameter int CLOCK_FREQ             = 50000000,
    parameter int DEBOUNCE_CYCLES        = CLOCK_FREQ / 50,
    parameter int DEBOUNCE_COUNTER_WIDTH = $clog2(DEBOUNCE_CYCLES + 1),
    parameter int NUM_KEYS               = 4
) (
    input logic                  clock,
    input logic                  reset,
    keypad_conditioner_if.master kp
);
    localparam int CW = DEBOUNCE_COUNTER_WIDTH;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [NUM_KEYS-1:0] ONE = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        LOCKOUT = 2'd2
    } state_t;

    logic [NUM_KEYS-1:0] sync1;
    logic [NUM_KEYS-1:0] sync2;
    logic [NUM_KEYS-1:0] deb;
    logic [CW-1:0]       cnt [NUM_KEYS];

    state_t              state, state_d;
    logic [NUM_KEYS-1:0] key_q, key_d;
    logic                strobe_q, strobe_d;
    logic                multi_q, multi_d;
    logic                deb_zero;
    logic                deb_one;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            for (int i = 0; i < NUM_KEYS; i++) cnt[i] <= '0;
        end else begin
            sync1 <= ~kp.key_n;
            sync2 <= sync1;
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= ~deb[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign deb_zero = (deb == '0);
    assign deb_one  = !deb_zero && ((deb & (deb - ONE)) == '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            key_q    <= '0;
            strobe_q <= 1'b0;
            multi_q  <= 1'b0;
        end else begin
            state    <= state_d;
            key_q    <= key_d;
            strobe_q <= strobe_d;
            multi_q  <= multi_d;
        end
    end

    always_comb begin
        state_d  = state;
        key_d    = key_q;
        strobe_d = 1'b0;
        multi_d  = multi_q;
        case (state)
            IDLE: begin
                key_d   = '0;
                multi_d = 1'b0;
                if (deb_one) begin
                    state_d  = ACTIVE;
                    key_d    = deb;
                    strobe_d = 1'b1;
                end else if (!deb_zero) begin
                    state_d = LOCKOUT;
                    multi_d = 1'b1;
                end
            end
            ACTIVE: begin
                multi_d = 1'b0;
                if (deb_zero) begin
                    state_d = IDLE;
                    key_d   = '0;
                end else if (deb != key_q) begin
                    // any change away from the latched key is ambiguous
                    state_d = LOCKOUT;
                    key_d   = '0;
                    multi_d = 1'b1;
                end
            end
            LOCKOUT: begin
                key_d   = '0;
                multi_d = 1'b1;
                if (deb_zero) begin
                    state_d = IDLE;
                    multi_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                key_d   = '0;
                multi_d = 1'b0;
            end
        endcase
    end

    assign kp.key       = key_q;
    assign kp.keyStrobe = strobe_q;
    assign kp.multiKey  = multi_q;
endmodule

// File: tb/tb_keypad_conditioner.sv
// Directed bench for keypad_conditioner with DEBOUNCE_CYCLES=8
// (11-edge latency from a clean key_n edge to key).
module tb_keypad_conditioner;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   strobes = 0;
    int   nz = 0;
    logic [3:0] slog [0:63];

    keypad_conditioner_if #(.NUM_KEYS(4)) kif ();

    keypad_conditioner #(
        .CLOCK_FREQ(1000),
        .DEBOUNCE_CYCLES(8),
        .NUM_KEYS(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .kp(kif.master)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (kif.keyStrobe === 1'b1) begin
            if (strobes < 64) slog[strobes] = kif.key;
            strobes++;
        end
        if (kif.key !== 4'b0000) nz++;
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [3:0] v);
        @(negedge clock);
        kif.key_n = v;
    endtask

    task automatic test_reset;
        kif.key_n = 4'b1111;
        #12;
        total++;
        if (kif.key !== 4'b0000) begin
            bad++; $display("FAIL rst_key got=%b exp=0000", kif.key);
        end
        total++;
        if (kif.keyStrobe !== 1'b0) begin
            bad++; $display("FAIL rst_strobe got=%b exp=0", kif.keyStrobe);
        end
        total++;
        if (kif.multiKey !== 1'b0) begin
            bad++; $display("FAIL rst_multi got=%b exp=0", kif.multiKey);
        end
        @(negedge clock);
        reset = 1'b1;
        edges(3);
    endtask

    task automatic test_single;
        drive(4'b1110);
        edges(10);
        total++;
        if (kif.key !== 4'b0000) begin
            bad++; $display("FAIL t1_early got=%b exp=0000", kif.key);
        end
        edges(1);
        total++;
        if (kif.key !== 4'b0001) begin
            bad++; $display("FAIL t1_press got=%b exp=0001", kif.key);
        end
        total++;
        if (kif.keyStrobe !== 1'b1) begin
            bad++; $display("FAIL t1_strobe got=%b exp=1", kif.keyStrobe);
        end
        edges(1);
        total++;
        if (kif.keyStrobe !== 1'b0 || kif.key !== 4'b0001) begin
            bad++;
            $display("FAIL t1_hold strobe=%b key=%b exp=0/0001",
                     kif.keyStrobe, kif.key);
        end
        drive(4'b1111);
        edges(10);
        total++;
        if (kif.key !== 4'b0001) begin
            bad++; $display("FAIL t1_rel_early got=%b exp=0001", kif.key);
        end
        edges(1);
        total++;
        if (kif.key !== 4'b0000) begin
            bad++; $display("FAIL t1_release got=%b exp=0000", kif.key);
        end
        edges(4);
    endtask

    task automatic test_bounce;
        int nz0, s0;
        logic [3:0] v;
        nz0 = nz;
        s0  = strobes;
        v   = 4'b1111;
        for (int i = 0; i < 14; i++) begin
            v[2] = ~v[2];
            drive(v);
            edges(2);
        end
        drive(4'b1011);
        total++;
        if (nz != nz0) begin
            bad++; $display("FAIL t2_bounce nz_cycles=%0d exp=0", nz - nz0);
        end
        edges(10);
        total++;
        if (kif.key !== 4'b0000) begin
            bad++; $display("FAIL t2_early got=%b exp=0000", kif.key);
        end
        edges(1);
        total++;
        if (kif.key !== 4'b0100) begin
            bad++; $display("FAIL t2_press got=%b exp=0100", kif.key);
        end
        edges(3);
        total++;
        if (strobes - s0 != 1) begin
            bad++; $display("FAIL t2_strobes got=%0d exp=1", strobes - s0);
        end
        drive(4'b1111);
        edges(14);
    endtask

    task automatic test_multi;
        int s0;
        s0 = strobes;
        drive(4'b0111);
        edges(20);
        total++;
        if (kif.key !== 4'b1000) begin
            bad++; $display("FAIL t3_first got=%b exp=1000", kif.key);
        end
        drive(4'b0110);
        edges(12);
        total++;
        if (kif.key !== 4'b0000 || kif.multiKey !== 1'b1) begin
            bad++;
            $display("FAIL t3_lock key=%b multi=%b exp=0000/1",
                     kif.key, kif.multiKey);
        end
        drive(4'b1110);
        edges(15);
        total++;
        if (kif.key !== 4'b0000 || kif.multiKey !== 1'b1) begin
            bad++;
            $display("FAIL t3_one_left key=%b multi=%b exp=0000/1",
                     kif.key, kif.multiKey);
        end
        drive(4'b1111);
        edges(10);
        total++;
        if (kif.multiKey !== 1'b1) begin
            bad++; $display("FAIL t3_rel_early got=%b exp=1", kif.multiKey);
        end
        edges(1);
        total++;
        if (kif.multiKey !== 1'b0) begin
            bad++; $display("FAIL t3_unlock got=%b exp=0", kif.multiKey);
        end
        total++;
        if (strobes - s0 != 1) begin
            bad++; $display("FAIL t3_strobes got=%0d exp=1", strobes - s0);
        end
        edges(3);
    endtask

    task automatic test_simultaneous;
        int s0, nz0;
        s0  = strobes;
        nz0 = nz;
        drive(4'b1001);
        edges(11);
        total++;
        if (kif.multiKey !== 1'b1) begin
            bad++; $display("FAIL t4_lock got=%b exp=1", kif.multiKey);
        end
        drive(4'b1011);
        edges(15);
        total++;
        if (kif.multiKey !== 1'b1) begin
            bad++; $display("FAIL t4_one_left got=%b exp=1", kif.multiKey);
        end
        drive(4'b1111);
        edges(11);
        total++;
        if (kif.multiKey !== 1'b0) begin
            bad++; $display("FAIL t4_unlock got=%b exp=0", kif.multiKey);
        end
        total++;
        if (strobes != s0 || nz != nz0) begin
            bad++;
            $display("FAIL t4_quiet strobes=%0d nz=%0d exp=0/0",
                     strobes - s0, nz - nz0);
        end
        edges(3);
    endtask

    task automatic test_reset_mid_press;
        int s0;
        s0 = strobes;
        drive(4'b1110);
        edges(14);
        total++;
        if (kif.key !== 4'b0001) begin
            bad++; $display("FAIL t5_before got=%b exp=0001", kif.key);
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        total++;
        if (kif.key !== 4'b0000 || kif.multiKey !== 1'b0) begin
            bad++;
            $display("FAIL t5_async key=%b multi=%b exp=0000/0",
                     kif.key, kif.multiKey);
        end
        @(negedge clock);
        reset = 1'b1;
        edges(10);
        total++;
        if (kif.key !== 4'b0000) begin
            bad++; $display("FAIL t5_early got=%b exp=0000", kif.key);
        end
        edges(1);
        total++;
        if (kif.key !== 4'b0001 || kif.keyStrobe !== 1'b1) begin
            bad++;
            $display("FAIL t5_again key=%b strobe=%b exp=0001/1",
                     kif.key, kif.keyStrobe);
        end
        edges(3);
        total++;
        if (strobes - s0 != 2) begin
            bad++; $display("FAIL t5_strobes got=%0d exp=2", strobes - s0);
        end
        drive(4'b1111);
        edges(14);
    endtask

    task automatic test_lock_sequence;
        logic [3:0] code [4];
        int s0, st;
        code[0] = 4'b1000;
        code[1] = 4'b0001;
        code[2] = 4'b0100;
        code[3] = 4'b1000;
        s0 = strobes;
        for (int i = 0; i < 4; i++) begin
            drive(~code[i]);
            edges(14);
            drive(4'b1111);
            edges(14);
        end
        total++;
        if (strobes - s0 != 4) begin
            bad++; $display("FAIL t6_strobes got=%0d exp=4", strobes - s0);
        end
        st = 0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (slog[s0 + i] !== code[i]) begin
                bad++;
                $display("FAIL t6_seq%0d got=%b exp=%b",
                         i, slog[s0 + i], code[i]);
            end
            if (slog[s0 + i] === code[st]) st++;
            else st = (slog[s0 + i] === code[0]) ? 1 : 0;
        end
        total++;
        if (st != 4) begin
            bad++; $display("FAIL t6_lock state=%0d exp=4", st);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_bounce;
        test_multi;
        test_simultaneous;
        test_reset_mid_press;
        test_lock_sequence;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
